// File: rtl/bitty_ctrl_pkg.sv
// Shared definitions for the bitty ALU control unit: FSM state encoding,
// instruction format codes and instruction field bit positions.
// Used by bitty_ctrl; the register file is width-parameterised and standalone.
package bitty_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [1:0] FMT_ALU = 2'b00;
  localparam logic [1:0] FMT_LDI = 2'b01;
  localparam logic [1:0] FMT_CMP = 2'b10;
  localparam logic [1:0] FMT_ILL = 2'b11;

  // Instruction field positions (low bit of each field unless noted)
  localparam int RX_LO    = 13;
  localparam int RY_LO    = 10;
  localparam int SEL_LO   = 6;
  localparam int SEL_W    = 4;
  localparam int MODE_BIT = 5;
  localparam int IMM_LO   = 5;
  localparam int IMM_W    = 8;
  localparam int FMT_LO   = 0;

endpackage

// File: rtl/bitty_regfile.sv
// Register file: 2**REG_ADDR_W x DATA_W, two combinational operand reads plus a debug read.
// Latency: reads combinational, write lands on the rising edge; synchronous reset clears all.
// Option BITTY_CTRL_R0_ZERO_EN: R0 reads as zero and writes to it are dropped.
module bitty_regfile #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int NREG = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_ok;

`ifdef BITTY_CTRL_R0_ZERO_EN
  assign wr_ok     = wr_en && (wr_addr != '0);
  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
  assign dbg_data  = (dbg_addr  == '0) ? '0 : regs[dbg_addr];
`else
  assign wr_ok     = wr_en;
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign dbg_data  = regs[dbg_addr];
`endif

  // Storage: clear everything on reset, otherwise a single write per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/bitty_ctrl.sv
// Control unit driving the bitty ALU: decode, operand fetch, execute, writeback.
// Latency: ALU/CMP retire 3 cycles after accept, LDI and illegal retire 1 cycle after accept.
// Backpressure: instr_ready only in IDLE; one instruction in flight. Option: BITTY_CTRL_R0_ZERO_EN.
module bitty_ctrl
  import bitty_ctrl_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [DATA_W-1:0]     alu_in_a,
  output logic [DATA_W-1:0]     alu_in_b,
  output logic [3:0]            alu_select,
  output logic                  alu_mode,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_carry,
  input  logic                  alu_compare,
  output logic                  carry_flag,
  output logic                  compare_flag,
  output logic                  done,
  output logic                  err,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  state_t                  state, state_nxt;
  logic [15:0]             ir;
  logic [DATA_W-1:0]       result;
  logic [REG_ADDR_W-1:0]   rx, ry;
  logic [1:0]              ir_fmt, in_fmt;
  logic [DATA_W-1:0]       rd_a, rd_b;
  logic                    wr_en;
  logic [DATA_W-1:0]       wr_data;
  logic [DATA_W-1:0]       imm_ext;

  // Reserved bits [4:2] carry no meaning
  logic unused_rsvd;
  assign unused_rsvd = ^ir[4:2];

  assign rx      = ir[RX_LO +: REG_ADDR_W];
  assign ry      = ir[RY_LO +: REG_ADDR_W];
  assign ir_fmt  = ir[FMT_LO +: 2];
  assign in_fmt  = instr[FMT_LO +: 2];
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, ir[IMM_LO +: IMM_W]};

  assign instr_ready = (state == IDLE) && !reset;
  assign done        = (state == WB) && !reset;
  assign err         = done && (ir_fmt == FMT_ILL);
  assign wr_en       = done && ((ir_fmt == FMT_ALU) || (ir_fmt == FMT_LDI));
  assign wr_data     = (ir_fmt == FMT_LDI) ? imm_ext : result;

  bitty_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rx),
    .rd_data_a (rd_a),
    .rd_addr_b (ry),
    .rd_data_b (rd_b),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_en     (wr_en),
    .wr_addr   (rx),
    .wr_data   (wr_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: ALU/CMP take the full operand path, LDI/illegal go straight to writeback
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          if ((in_fmt == FMT_ALU) || (in_fmt == FMT_CMP)) state_nxt = FETCH;
          else                                            state_nxt = WB;
        end
      end
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: IR on accept, ALU operands in FETCH, result and flags in EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      ir           <= '0;
      result       <= '0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_select   <= '0;
      alu_mode     <= 1'b0;
      carry_flag   <= 1'b0;
      compare_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) ir <= instr;
        FETCH: begin
          alu_in_a   <= rd_a;
          alu_in_b   <= rd_b;
          alu_select <= ir[SEL_LO +: SEL_W];
          alu_mode   <= ir[MODE_BIT];
        end
        EXEC: begin
          result       <= alu_out;
          carry_flag   <= alu_carry;
          compare_flag <= alu_compare;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_ctrl.sv
// Directed bench for bitty_ctrl with a behavioural ALU, a register/flag reference
// model and a scoreboard queue of expected retirements.
module tb_bitty_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_in_a, alu_in_b, alu_out;
  logic [3:0]  alu_select;
  logic        alu_mode, alu_carry, alu_compare;
  logic        carry_flag, compare_flag, done, err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          lat;
    logic        err;
    logic [2:0]  rx;
    logic [15:0] old_val;
    logic [15:0] new_val;
    logic        cf;
    logic        zf;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] m_r [8];
  logic        m_cf, m_zf;

  always #5 clk = ~clk;

  bitty_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_select   (alu_select),
    .alu_mode     (alu_mode),
    .alu_out      (alu_out),
    .alu_carry    (alu_carry),
    .alu_compare  (alu_compare),
    .carry_flag   (carry_flag),
    .compare_flag (compare_flag),
    .done         (done),
    .err          (err),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Subset of the 74181-style bitty ALU: {carry, result}
  function automatic logic [16:0] alu_f(input logic [3:0] sel, input logic mode,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    case ({mode, sel})
      5'b1_0000: r = {1'b0, ~a};
      5'b1_0110: r = {1'b0, a ^ b};
      5'b0_1001: r = {1'b0, a} + {1'b0, b};
      default:   r = {1'b0, a};
    endcase
    return r;
  endfunction

  always_comb begin
    {alu_carry, alu_out} = alu_f(alu_select, alu_mode, alu_in_a, alu_in_b);
    alu_compare          = (alu_in_a == alu_in_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction, predict its effect, then check retirement against the scoreboard
  task automatic issue(input logic [15:0] w);
    exp_t        e, g;
    logic [16:0] r;
    logic [2:0]  ry;
    int          n;
    int          lat;
    e.rx    = w[15:13];
    ry      = w[12:10];
    e.old_val = m_r[e.rx];
    e.new_val = e.old_val;
    e.cf    = m_cf;
    e.zf    = m_zf;
    e.err   = 1'b0;
    r = alu_f(w[9:6], w[5], m_r[e.rx], m_r[ry]);
    case (w[1:0])
      2'b00: begin e.lat = 3; e.new_val = r[15:0]; e.cf = r[16]; e.zf = (m_r[e.rx] == m_r[ry]); end
      2'b01: begin e.lat = 1; e.new_val = {8'h00, w[12:5]}; end
      2'b10: begin e.lat = 3; e.cf = r[16]; e.zf = (m_r[e.rx] == m_r[ry]); end
      default: begin e.lat = 1; e.err = 1'b1; end
    endcase
    sb.push_back(e);

    dbg_addr    = e.rx;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    check("ready_before_accept", {31'b0, instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'h0000;

    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin lat = c; break; end
    end
    g = sb.pop_front();
    check("done_latency", lat, g.lat);
    check("err_in_wb", {31'b0, err}, {31'b0, g.err});
    check("dbg_prewrite", {16'b0, dbg_data}, {16'b0, g.old_val});
    @(negedge clk);
    check("dbg_postwrite", {16'b0, dbg_data}, {16'b0, g.new_val});
    check("carry_flag", {31'b0, carry_flag}, {31'b0, g.cf});
    check("compare_flag", {31'b0, compare_flag}, {31'b0, g.zf});
    check("done_one_cycle", {30'b0, done, err}, 32'd0);
    check("ready_after", {31'b0, instr_ready}, 32'd1);
    m_r[g.rx] = g.new_val;
    m_cf      = g.cf;
    m_zf      = g.zf;
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_addr    = 3'd0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_cf = 1'b0;
    m_zf = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {31'b0, instr_ready}, 32'd0);
    check("done_in_reset", {30'b0, done, err}, 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'b0, instr_ready}, 32'd1);
    check("flags_after_reset", {30'b0, carry_flag, compare_flag}, 32'd0);
    check("done_after_reset", {30'b0, done, err}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      check("reg_after_reset", {16'b0, dbg_data}, 32'd0);
    end

    issue(16'h2241);   // LDI R1, 0x12
    issue(16'h4681);   // LDI R2, 0x34
    issue(16'h2A40);   // ADD R1, R2 -> 0x46
    issue(16'h8020);   // NOT R4 -> 0xFFFF
    issue(16'h9240);   // ADD R4, R4 -> 0xFFFE, carry
    issue(16'h0003);   // illegal: err, no changes
    issue(16'h2402);   // CMP R1, R1 -> compare
    issue(16'h2802);   // CMP R1, R2 -> not equal
    dbg_addr = 3'd1;
    #1;
    check("r1_final", {16'b0, dbg_data}, 32'h0046);
    dbg_addr = 3'd4;
    #1;
    check("r4_final", {16'b0, dbg_data}, 32'hFFFE);

    // Reset during EXEC of an ADD: no writeback may follow
    dbg_addr = 3'd1;
    @(negedge clk);
    instr       = 16'h2A40;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    @(negedge clk);          // FETCH
    @(negedge clk);          // EXEC
    check("no_done_in_exec", {31'b0, done}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_done", {30'b0, done, err}, 32'd0);
    check("reset_mid_r1", {16'b0, dbg_data}, 32'd0);
    reset = 1'b0;
    #1;
    check("reset_mid_ready", {31'b0, instr_ready}, 32'd1);
    check("reset_mid_flags", {30'b0, carry_flag, compare_flag}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_late_done", {30'b0, done, err}, 32'd0);
      check("r1_stays_zero", {16'b0, dbg_data}, 32'd0);
    end
    dbg_addr = 3'd2;
    #1;
    check("r2_cleared", {16'b0, dbg_data}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitty_ctrl.md
Name: bitty_ctrl

Overview:
- Control/sequencing unit on the driving side of the bitty ALU.
- Accepts one 16-bit instruction per valid/ready handshake and decodes it into ALU select/mode.
- Fetches operands from an internal 8x16 register file, presents them to the ALU, latches alu_out/carry/compare, and writes the result back.
- Sits between the instruction source (fetch stage or testbench) and the combinational ALU.

Parameters:
- DATA_W, 16, datapath width; must match the ALU width.
- REG_ADDR_W, 3, register index width; gives 2**REG_ADDR_W registers.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  unit can accept an instruction
- instr  in  16  instruction word
- alu_in_a  out  DATA_W  operand A to ALU
- alu_in_b  out  DATA_W  operand B to ALU
- alu_select  out  4  ALU function select
- alu_mode  out  1  ALU mode (0 arithmetic, 1 logic)
- alu_out  in  DATA_W  ALU result
- alu_carry  in  1  ALU carry_out
- alu_compare  in  1  ALU compare (A==B)
- carry_flag  out  1  sticky carry from last executed ALU op
- compare_flag  out  1  compare from last executed ALU op
- done  out  1  one-cycle pulse when an instruction retires
- err  out  1  one-cycle pulse on an illegal instruction
- dbg_addr  in  REG_ADDR_W  debug read index
- dbg_data  out  DATA_W  combinational read of R[dbg_addr]

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE, all registers 0, alu_in_a/b 0, alu_select 0, alu_mode 0, carry_flag 0, compare_flag 0, done 0, err 0.
- Handshake:
  - instr_ready = (state==IDLE) && !reset.
  - Accept on rising clk when instr_valid && instr_ready; the instruction is latched into an internal IR.
  - instr is ignored outside IDLE.
- Instruction fields:
  - [15:13] rx
  - [12:10] ry
  - [9:6] select
  - [5] mode
  - [4:2] reserved, ignored
  - [1:0] fmt
- fmt 00, ALU op, R[rx] <= ALU(R[rx], R[ry]): IDLE -> FETCH -> EXEC -> WB -> IDLE.
- fmt 01, LDI: R[rx] <= {8'b0, instr[12:5]}, no ALU access, IDLE -> WB -> IDLE.
- fmt 10, CMP: same path as fmt 00, but flags are updated and no register is written.
- fmt 11, illegal: IDLE -> WB with no write and no flag change; err=1 and done=1 in WB.
- FETCH: register alu_in_a <= R[rx], alu_in_b <= R[ry], alu_select <= select, alu_mode <= mode.
- EXEC: ALU is combinational on the registered operands. Latch result <= alu_out, carry_flag <= alu_carry, compare_flag <= alu_compare.
- WB: perform the write if applicable and pulse done. ALU-op retirement occurs 3 cycles after accept; LDI occurs 1 cycle after accept.
- ALU-port outputs hold their last values outside FETCH.
- rx==ry is legal; both operands read the same register.
- Reset asserted in any state:
  - next state IDLE, registers cleared, and no pending writeback occurs;
  - done and err stay 0.
- dbg_data reflects the pre-write value during WB; the new value is visible the cycle after.

Optional Feature:
- BITTY_CTRL_R0_ZERO_EN defined: R0 reads 0 always, and writes to R0 are discarded (done still pulses).
- Undefined: R0 is an ordinary register.

Decomposition:
- Package bitty_ctrl_pkg holds:
  - state encoding (IDLE, FETCH, EXEC, WB);
  - fmt constants (FMT_ALU=2'b00, FMT_LDI=2'b01, FMT_CMP=2'b10, FMT_ILL=2'b11);
  - field bit positions.
- Sub-module bitty_regfile: 8xDATA_W, two combinational read ports plus a debug read port, one synchronous write port, synchronous reset clear, and the R0_ZERO option.

Test Plan:
- Reset held 2 cycles then released: all dbg reads return 0x0000, instr_ready=1, flags=0, done=0.
- LDI 0x2241 then 0x4681: R1=0x0012, R2=0x0034; each done pulses 1 cycle after accept.
- ADD 0x2A40, with the real ALU: done pulses 3 cycles after accept, R1=0x0046, carry_flag=0.
- NOT R4 (0x8020) then ADD R4,R4 (0x9240):
  - R4 is 0xFFFF after the NOT;
  - R4 is 0xFFFE after the ADD, with carry_flag=1.
- CMP R1,R1 (0x2402): compare_flag=1, R1 unchanged.
- Illegal fmt 0x0003: err and done pulse together, no register or flag change.
- Reset asserted during EXEC of 0x2A40: no writeback, R1=0x0000 after reset, instr_ready=1 next cycle.
